// File: rtl/rob_pkg.sv
// Shared reorder-buffer configuration: queue depth, entry type encoding
// and pointer helpers used by the ROB and its neighbours.
package rob_pkg;

    localparam int ROB_SIZE_WIDTH = 4;
    localparam int ROB_SIZE       = 1 << ROB_SIZE_WIDTH;

    localparam logic [ROB_SIZE_WIDTH:0]   ROB_COUNT_FULL = (ROB_SIZE_WIDTH + 1)'(ROB_SIZE);
    localparam logic [ROB_SIZE_WIDTH:0]   ROB_COUNT_ONE  = (ROB_SIZE_WIDTH + 1)'(1);
    localparam logic [ROB_SIZE_WIDTH-1:0] ROB_PTR_ONE    = ROB_SIZE_WIDTH'(1);

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'd0,
        ROB_TYPE_STORE  = 2'd1,
        ROB_TYPE_BRANCH = 2'd2,
        ROB_TYPE_EXIT   = 2'd3
    } rob_type_e;

    // Circular pointer advance; wraps naturally at the pointer width.
    function automatic logic [ROB_SIZE_WIDTH-1:0] rob_ptr_next(input logic [ROB_SIZE_WIDTH-1:0] p);
        return p + ROB_PTR_ONE;
    endfunction

endpackage

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions. Allocates ids
// at issue, absorbs RS/LSB result broadcasts, answers operand queries with
// same-cycle forwarding, and retires in order (register write, store
// release, branch check with flush, exit).
module rob
    import rob_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,

    input  logic                      issue_valid,
    input  logic [1:0]                issue_type,
    input  logic [4:0]                issue_rd,
    input  logic                      issue_ready,
    input  logic [31:0]               issue_value,
    input  logic [31:0]               issue_pred_pc,
    output logic                      rob_full,
    output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,

    input  logic [ROB_SIZE_WIDTH-1:0] query_id1,
    input  logic [ROB_SIZE_WIDTH-1:0] query_id2,
    output logic                      query_ready1,
    output logic                      query_ready2,
    output logic [31:0]               query_value1,
    output logic [31:0]               query_value2,

    input  logic                      rs_ready,
    input  logic [ROB_SIZE_WIDTH-1:0] rs_rob_id,
    input  logic [31:0]               rs_value,
    input  logic                      lsb_ready,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]               lsb_value,

    output logic                      commit_reg_valid,
    output logic [4:0]                commit_rd,
    output logic [31:0]               commit_value,
    output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
    output logic                      commit_store_valid,
    output logic                      rob_clear,
    output logic [31:0]               clear_pc,
    output logic                      halted
);

    logic [ROB_SIZE_WIDTH-1:0]         head_q;
    logic [ROB_SIZE_WIDTH-1:0]         tail_q;
    logic [ROB_SIZE_WIDTH:0]           count_q;

    logic [ROB_SIZE-1:0]               busy_q;
    logic [ROB_SIZE-1:0]               ready_q;
    logic [ROB_SIZE-1:0][31:0]         value_q;
    rob_type_e [ROB_SIZE-1:0]          type_q;
    logic [ROB_SIZE-1:0][4:0]          rd_q;
    logic [ROB_SIZE-1:0][31:0]         pred_pc_q;

    rob_type_e                         issue_kind;
    rob_type_e                         head_kind;
    logic                              do_issue;
    logic                              do_commit;
    logic                              mispredict;
    logic                              rs_hit;
    logic                              lsb_hit;

    assign issue_kind   = rob_type_e'(issue_type);
    assign head_kind    = type_q[head_q];
    assign rob_full     = (count_q == ROB_COUNT_FULL);
    assign issue_rob_id = tail_q;

    // The flush cycle (rob_clear high) ignores new issues and broadcasts.
    assign do_issue   = issue_valid && !rob_full && !rob_clear;
    assign do_commit  = busy_q[head_q] && ready_q[head_q] && !halted;
    assign mispredict = do_commit && (head_kind == ROB_TYPE_BRANCH)
                        && (value_q[head_q] != pred_pc_q[head_q]);
    assign rs_hit     = rs_ready && busy_q[rs_rob_id] && !rob_clear;
    assign lsb_hit    = lsb_ready && busy_q[lsb_rob_id] && !rob_clear;

    // Operand lookup with same-cycle broadcast forwarding; rs overrides lsb.
    always_comb begin
        query_ready1 = ready_q[query_id1];
        query_value1 = value_q[query_id1];
        if (lsb_ready && (lsb_rob_id == query_id1)) begin
            query_ready1 = 1'b1;
            query_value1 = lsb_value;
        end
        if (rs_ready && (rs_rob_id == query_id1)) begin
            query_ready1 = 1'b1;
            query_value1 = rs_value;
        end

        query_ready2 = ready_q[query_id2];
        query_value2 = value_q[query_id2];
        if (lsb_ready && (lsb_rob_id == query_id2)) begin
            query_ready2 = 1'b1;
            query_value2 = lsb_value;
        end
        if (rs_ready && (rs_rob_id == query_id2)) begin
            query_ready2 = 1'b1;
            query_value2 = rs_value;
        end
    end

    // Queue control, entry status/value and the registered commit/flush pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            busy_q             <= '0;
            ready_q            <= '0;
            value_q            <= '0;
            halted             <= 1'b0;
            commit_reg_valid   <= 1'b0;
            commit_rd          <= '0;
            commit_value       <= '0;
            commit_rob_id      <= '0;
            commit_store_valid <= 1'b0;
            rob_clear          <= 1'b0;
            clear_pc           <= '0;
        end else begin
            commit_reg_valid   <= 1'b0;
            commit_store_valid <= 1'b0;
            rob_clear          <= 1'b0;
            if (rdy) begin
                if (mispredict) begin
                    // Wrong-path work behind the branch is discarded wholesale.
                    head_q    <= '0;
                    tail_q    <= '0;
                    count_q   <= '0;
                    busy_q    <= '0;
                    ready_q   <= '0;
                    rob_clear <= 1'b1;
                    clear_pc  <= value_q[head_q];
                end else begin
                    if (do_issue) begin
                        busy_q[tail_q]  <= 1'b1;
                        ready_q[tail_q] <= issue_ready || (issue_kind == ROB_TYPE_STORE)
                                           || (issue_kind == ROB_TYPE_EXIT);
                        value_q[tail_q] <= issue_value;
                        tail_q          <= rob_ptr_next(tail_q);
                    end
                    if (lsb_hit) begin
                        ready_q[lsb_rob_id] <= 1'b1;
                        value_q[lsb_rob_id] <= lsb_value;
                    end
                    if (rs_hit) begin
                        ready_q[rs_rob_id] <= 1'b1;
                        value_q[rs_rob_id] <= rs_value;
                    end
                    if (do_commit) begin
                        busy_q[head_q] <= 1'b0;
                        head_q         <= rob_ptr_next(head_q);
                        unique case (head_kind)
                            ROB_TYPE_REG: begin
                                commit_reg_valid <= 1'b1;
                                commit_rd        <= rd_q[head_q];
                                commit_value     <= value_q[head_q];
                                commit_rob_id    <= head_q;
                            end
                            ROB_TYPE_STORE:  commit_store_valid <= 1'b1;
                            ROB_TYPE_EXIT:   halted             <= 1'b1;
                            ROB_TYPE_BRANCH: ;
                        endcase
                    end
                    unique case ({do_issue, do_commit})
                        2'b10:   count_q <= count_q + ROB_COUNT_ONE;
                        2'b01:   count_q <= count_q - ROB_COUNT_ONE;
                        default: count_q <= count_q;
                    endcase
                end
            end
        end
    end

    // Static entry fields, only meaningful while the entry is busy.
    always_ff @(posedge clk) begin
        if (rdy && do_issue && !mispredict) begin
            type_q[tail_q]    <= issue_kind;
            rd_q[tail_q]      <= issue_rd;
            pred_pc_q[tail_q] <= issue_pred_pc;
        end
    end

endmodule

// File: tb/tb_rob.sv
// Randomized bench for the reorder buffer against a queue-based model.
module tb_rob;
    import rob_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        issue_valid, issue_ready;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_value, issue_pred_pc;
    logic        rob_full;
    logic [3:0]  issue_rob_id;
    logic [3:0]  query_id1, query_id2;
    logic        query_ready1, query_ready2;
    logic [31:0] query_value1, query_value2;
    logic        rs_ready, lsb_ready;
    logic [3:0]  rs_rob_id, lsb_rob_id;
    logic [31:0] rs_value, lsb_value;
    logic        commit_reg_valid, commit_store_valid, rob_clear, halted;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value, clear_pc;
    logic [3:0]  commit_rob_id;

    rob dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .issue_value(issue_value), .issue_pred_pc(issue_pred_pc),
        .rob_full(rob_full), .issue_rob_id(issue_rob_id),
        .query_id1(query_id1), .query_id2(query_id2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_value1(query_value1), .query_value2(query_value2),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .commit_reg_valid(commit_reg_valid), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_rob_id(commit_rob_id),
        .commit_store_valid(commit_store_valid), .rob_clear(rob_clear),
        .clear_pc(clear_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [1:0]  typ;
        logic [4:0]  rd;
        bit          rdy;
        logic [31:0] val;
        logic [31:0] pred;
    } ent_t;

    ent_t        q[$];
    int          tail_m;
    bit          halted_m;
    bit          e_reg_v, e_st_v, e_clr;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_cpc;
    int          e_id;
    int          n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find(input int id);
        for (int k = 0; k < q.size(); k++)
            if (q[k].id == id) return k;
        return -1;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 2))
            0:       return 32'h100;
            1:       return 32'h200;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] pick_id();
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
            return 4'(q[$urandom_range(0, q.size() - 1)].id);
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic model_reset();
        q.delete();
        tail_m = 0; halted_m = 0;
        e_reg_v = 0; e_st_v = 0; e_clr = 0;
        e_rd = 0; e_val = 0; e_cpc = 0; e_id = 0;
    endtask

    task automatic idle_inputs();
        rdy = 1; issue_valid = 0; issue_type = 0; issue_rd = 0; issue_ready = 0;
        issue_value = 0; issue_pred_pc = 0; query_id1 = 0; query_id2 = 0;
        rs_ready = 0; rs_rob_id = 0; rs_value = 0;
        lsb_ready = 0; lsb_rob_id = 0; lsb_value = 0;
    endtask

    task automatic check_regs();
        chk("rob_full", rob_full, q.size() == 16);
        chk("issue_rob_id", issue_rob_id, tail_m);
        chk("commit_reg_valid", commit_reg_valid, e_reg_v);
        if (e_reg_v) begin
            chk("commit_rd", commit_rd, e_rd);
            chk("commit_value", commit_value, e_val);
            chk("commit_rob_id", commit_rob_id, e_id);
        end
        chk("commit_store_valid", commit_store_valid, e_st_v);
        chk("rob_clear", rob_clear, e_clr);
        if (e_clr) chk("clear_pc", clear_pc, e_cpc);
        chk("halted", halted, halted_m);
    endtask

    task automatic check_query(input string tag, input logic [3:0] id,
                               input logic r, input logic [31:0] v);
        bit er; logic [31:0] ev; int k;
        if (rs_ready && rs_rob_id == id) begin er = 1; ev = rs_value; end
        else if (lsb_ready && lsb_rob_id == id) begin er = 1; ev = lsb_value; end
        else begin
            k = find(id);
            if (k < 0) return;
            er = q[k].rdy; ev = q[k].val;
        end
        chk({tag, "_ready"}, r, er);
        if (er) chk({tag, "_value"}, v, ev);
    endtask

    // Advance the model across one clock edge using the currently driven inputs.
    task automatic model_edge();
        int pre; bit clr_prev; bit com; int k; ent_t c, n;
        pre = q.size(); clr_prev = e_clr;
        e_reg_v = 0; e_st_v = 0; e_clr = 0;
        if (!rdy) return;
        com = !halted_m && pre > 0 && q[0].rdy;
        if (com && q[0].typ == ROB_TYPE_BRANCH && q[0].val != q[0].pred) begin
            e_clr = 1; e_cpc = q[0].val;
            q.delete(); tail_m = 0;
            return;
        end
        if (com) begin
            c = q.pop_front();
            case (c.typ)
                ROB_TYPE_REG:   begin e_reg_v = 1; e_rd = c.rd; e_val = c.val; e_id = c.id; end
                ROB_TYPE_STORE: e_st_v = 1;
                ROB_TYPE_EXIT:  halted_m = 1;
                default: ;
            endcase
        end
        if (!clr_prev) begin
            if (lsb_ready) begin k = find(lsb_rob_id); if (k >= 0) begin q[k].val = lsb_value; q[k].rdy = 1; end end
            if (rs_ready)  begin k = find(rs_rob_id);  if (k >= 0) begin q[k].val = rs_value;  q[k].rdy = 1; end end
            if (issue_valid && pre < 16) begin
                n.id = tail_m; n.typ = issue_type; n.rd = issue_rd; n.val = issue_value;
                n.pred = issue_pred_pc;
                n.rdy = issue_ready || issue_type == ROB_TYPE_STORE || issue_type == ROB_TYPE_EXIT;
                q.push_back(n);
                tail_m = (tail_m + 1) % 16;
            end
        end
    endtask

    // One cycle: drive random inputs after the edge, check queries, clock, check registers.
    task automatic step(input int p_bc, input bit allow_exit);
        int r;
        rdy = ($urandom_range(0, 9) != 0);
        issue_valid = $urandom_range(0, 1);
        r = $urandom_range(0, 99);
        if (r < 55)      issue_type = ROB_TYPE_REG;
        else if (r < 70) issue_type = ROB_TYPE_STORE;
        else if (r < 95) issue_type = ROB_TYPE_BRANCH;
        else             issue_type = allow_exit ? ROB_TYPE_EXIT : ROB_TYPE_REG;
        issue_rd = 5'($urandom);
        issue_ready = ($urandom_range(0, 3) == 0);
        issue_value = rand_val();
        issue_pred_pc = $urandom_range(0, 1) ? 32'h100 : 32'h200;
        rs_ready = ($urandom_range(0, 99) < p_bc);
        rs_rob_id = pick_id(); rs_value = rand_val();
        lsb_ready = ($urandom_range(0, 99) < p_bc);
        lsb_rob_id = pick_id(); lsb_value = rand_val();
        query_id1 = pick_id(); query_id2 = pick_id();
        #1;
        check_query("query1", query_id1, query_ready1, query_value1);
        check_query("query2", query_id2, query_ready2, query_value2);
        model_edge();
        @(posedge clk); #1;
        check_regs();
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock.
    task automatic async_reset();
        idle_inputs();
        rst = 1; #1;
        model_reset();
        check_regs();
        #2; rst = 0;
        @(posedge clk); #1;
        check_regs();
    endtask

    int bc_prob[6] = '{60, 10, 40, 5, 70, 50};

    initial begin
        n_chk = 0; n_fail = 0;
        idle_inputs();
        rst = 1;
        model_reset();
        #1;
        check_regs();
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        check_regs();
        for (int ph = 0; ph < 6; ph++) begin
            for (int cyc = 0; cyc < 300; cyc++) begin
                if (ph == 2 && cyc == 150) async_reset();
                step(bc_prob[ph], ph == 5);
            end
        end
        async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
